// File: rtl/census_line_feeder.sv
// Write-side sequencer for the 5-row Census line-buffer chain: raster position tracking,
// per-buffer write enables and 5x5 window flag. Optional line blanking: CENSUS_FEEDER_HBLANK_EN.
module census_line_feeder #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 11,
    parameter int HBLANK = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] width,
    input  logic [AWIDTH-1:0] height,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [DWIDTH-1:0] pix_in,
    output logic              pix_ready,
    output logic              clken,
    output logic              en2,
    output logic              en3,
    output logic              en4,
    output logic              en5,
    output logic [DWIDTH-1:0] pix_out,
    output logic [AWIDTH-1:0] col,
    output logic [AWIDTH-1:0] row,
    output logic              win_valid,
    output logic              frame_done,
    output logic              cfg_err,
    output logic              busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [AWIDTH-1:0] MIN_DIM = AWIDTH'(5);
    localparam logic [AWIDTH-1:0] WIN_MIN = AWIDTH'(4);
    localparam int BW = (HBLANK < 1) ? 1 : $clog2(HBLANK + 1);
`ifdef CENSUS_FEEDER_HBLANK_EN
    localparam int HBL_EFF = HBLANK;
`else
    // Disabled build keeps the counter but never loads it, so it reduces to constant zero.
    localparam int HBL_EFF = HBLANK * 0;
`endif

    logic [0:0]        state;
    logic [AWIDTH-1:0] w_q, h_q, col_cnt, row_cnt;
    logic [BW-1:0]     blank_cnt;
    logic              accept, line_end, last_pix, cfg_ok, blank;

    assign cfg_ok    = (width >= MIN_DIM) && (height >= MIN_DIM);
    assign blank     = (blank_cnt != '0);
    assign pix_ready = (state == RUN) && !blank;
    assign accept    = pix_valid && pix_ready;
    assign line_end  = (col_cnt == w_q - AWIDTH'(1));
    assign last_pix  = accept && line_end && (row_cnt == h_q - AWIDTH'(1));
    assign busy      = (state == RUN);

    // Enables qualify the live accept so the controller writes pix_in on this very edge.
    assign clken = accept;
    assign en2   = accept && (row_cnt >= AWIDTH'(1));
    assign en3   = accept && (row_cnt >= AWIDTH'(2));
    assign en4   = accept && (row_cnt >= AWIDTH'(3));
    assign en5   = accept && (row_cnt >= AWIDTH'(4));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_cnt <= '0;
        end else if (accept && line_end && !last_pix) begin
            blank_cnt <= BW'(HBL_EFF);
        end else if (blank) begin
            blank_cnt <= blank_cnt - BW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            w_q        <= '0;
            h_q        <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            pix_out    <= '0;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err    <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= last_pix;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state   <= RUN;
                            w_q     <= width;
                            h_q     <= height;
                            col_cnt <= '0;
                            row_cnt <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        pix_out   <= pix_in;
                        col       <= col_cnt;
                        row       <= row_cnt;
                        win_valid <= (row_cnt >= WIN_MIN) && (col_cnt >= WIN_MIN);
                        if (line_end) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + AWIDTH'(1);
                        end else begin
                            col_cnt <= col_cnt + AWIDTH'(1);
                        end
                        if (last_pix) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_census_line_feeder.sv
// Scoreboard bench for census_line_feeder: a cycle model predicts handshake/enables and
// queues expected registered outputs, popped one cycle later.
module tb_census_line_feeder;
    localparam int DW  = 8;
    localparam int AW  = 11;
    localparam int HBL = 2;
`ifdef CENSUS_FEEDER_HBLANK_EN
    localparam int HB_EFF = HBL;
`else
    localparam int HB_EFF = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] width = '0, height = '0;
    logic          start = 1'b0, pix_valid = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic          pix_ready, clken, en2, en3, en4, en5;
    logic [DW-1:0] pix_out;
    logic [AW-1:0] col, row;
    logic          win_valid, frame_done, cfg_err, busy;

    census_line_feeder #(.DWIDTH(DW), .AWIDTH(AW), .HBLANK(HBL)) dut (
        .clk(clk), .rst(rst), .width(width), .height(height), .start(start),
        .pix_valid(pix_valid), .pix_in(pix_in), .pix_ready(pix_ready), .clken(clken),
        .en2(en2), .en3(en3), .en4(en4), .en5(en5), .pix_out(pix_out), .col(col), .row(row),
        .win_valid(win_valid), .frame_done(frame_done), .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] pix;
        logic [AW-1:0] col;
        logic [AW-1:0] row;
        logic          win;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0, failures = 0;
    logic          m_run = 1'b0;
    logic [AW-1:0] m_col = '0, m_row = '0, m_w = '0, m_h = '0;
    int            m_blank = 0;
    int            d_acc, d_win, d_busy, d_en2_first, d_en5_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(pix_ready), 0);
        check({tag, "_clken"}, 32'(clken), 0);
        check({tag, "_en"}, 32'({en2, en3, en4, en5}), 0);
        check({tag, "_pix_out"}, 32'(pix_out), 0);
        check({tag, "_col"}, 32'(col), 0);
        check({tag, "_row"}, 32'(row), 0);
        check({tag, "_win"}, 32'(win_valid), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    // One clock: drive at negedge, check combinational outputs, then registered ones after the edge.
    task automatic step(input logic v, input logic s);
        logic exp_ready, acc, last, exp_cfg, lend;
        exp_t e;
        @(negedge clk);
        pix_valid = v;
        start     = s;
        pix_in    = DW'($urandom_range(0, 255));
        #1;
        exp_ready = m_run && (m_blank == 0);
        acc       = v && exp_ready;
        lend      = (m_col == m_w - AW'(1));
        last      = acc && lend && (m_row == m_h - AW'(1));
        exp_cfg   = s && !m_run && ((width < AW'(5)) || (height < AW'(5)));
        check("pix_ready", 32'(pix_ready), 32'(exp_ready));
        check("clken", 32'(clken), 32'(acc));
        check("en2", 32'(en2), 32'(acc && (m_row >= AW'(1))));
        check("en3", 32'(en3), 32'(acc && (m_row >= AW'(2))));
        check("en4", 32'(en4), 32'(acc && (m_row >= AW'(3))));
        check("en5", 32'(en5), 32'(acc && (m_row >= AW'(4))));
        check("busy", 32'(busy), 32'(m_run));
        if (clken === 1'b1) d_acc++;
        if (en2 === 1'b1 && d_en2_first == 0) d_en2_first = d_acc;
        if (en5 === 1'b1 && d_en5_first == 0) d_en5_first = d_acc;
        if (busy === 1'b1) d_busy++;
        if (acc) begin
            e.pix = pix_in;
            e.col = m_col;
            e.row = m_row;
            e.win = (m_row >= AW'(4)) && (m_col >= AW'(4));
            sb.push_back(e);
            if (lend) begin
                m_col = '0;
                m_row = m_row + AW'(1);
            end else begin
                m_col = m_col + AW'(1);
            end
        end
        if (acc && lend && !last) m_blank = HB_EFF;
        else if (m_blank > 0) m_blank--;
        if (s && !m_run && width >= AW'(5) && height >= AW'(5)) begin
            m_run = 1'b1;
            m_w   = width;
            m_h   = height;
            m_col = '0;
            m_row = '0;
        end else if (last) begin
            m_run = 1'b0;
        end
        @(posedge clk);
        #1;
        check("cfg_err", 32'(cfg_err), 32'(exp_cfg));
        check("frame_done", 32'(frame_done), 32'(last));
        if (win_valid === 1'b1) d_win++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pix_out", 32'(pix_out), 32'(e.pix));
            check("col", 32'(col), 32'(e.col));
            check("row", 32'(row), 32'(e.row));
            check("win_valid", 32'(win_valid), 32'(e.win));
        end else begin
            check("win_idle", 32'(win_valid), 0);
        end
    endtask

    task automatic run_frame(input int w, input int h, input bit toggle, input int stop_at);
        int   n;
        logic v;
        width = AW'(w);
        height = AW'(h);
        d_acc = 0; d_win = 0; d_busy = 0; d_en2_first = 0; d_en5_first = 0;
        step(1'b0, 1'b1);
        // Size inputs move mid-frame; the latched size must govern.
        width = AW'(3);
        height = AW'(3);
        v = 1'b1;
        n = 0;
        while (m_run && n < 400 && (stop_at == 0 || d_acc < stop_at - 1)) begin
            step(v, (m_col == m_w - AW'(1)) && (m_row == m_h - AW'(1)));
            if (toggle) v = ~v;
            n++;
        end
        check("frame_bound", 32'(n < 400), 1);
        if (stop_at == 0) begin
            check("accepts", 32'(d_acc), 32'(w * h));
            check("en2_first", 32'(d_en2_first), 32'(w + 1));
            check("en5_first", 32'(d_en5_first), 32'(4 * w + 1));
            check("win_count", 32'(d_win), 32'((w - 4) * (h - 4)));
            if (!toggle) check("frame_cycles", 32'(d_busy), 32'(w * h + HB_EFF * (h - 1)));
            step(1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        pix_valid = 1'b1;
        start = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        m_run = 1'b0; m_col = '0; m_row = '0; m_blank = 0;
        sb.delete();
        @(negedge clk);
        pix_valid = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        run_frame(8, 6, 1'b0, 0);
        run_frame(8, 6, 1'b1, 0);

        width = AW'(4);
        height = AW'(10);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        run_frame(5, 5, 1'b0, 0);

        run_frame(8, 6, 1'b0, 20);
        do_reset();
        step(1'b0, 1'b0);
        run_frame(8, 6, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
